clock_reconfig_sequencer: RTL and testbench
===========================================

CLOCK_RECONFIG_SEQUENCER -- requirements
Module: clock_reconfig_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 8, SHALL set DCM reset pulse length in clk_i cycles (legal range 1-255).
REQ-002 Parameter LOCK_STABLE, default 16, SHALL set consecutive locked cycles required to declare lock (legal range 1-255).
REQ-003 Parameter TIMEOUT, default 1000000, SHALL set the per-wait-state timeout in cycles (legal range 2 to 2^20-1, 20-bit counter).
REQ-004 clk_i  in  1  single block clock; all logic SHALL be on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 start_i  in  1  reconfiguration request; sampled in IDLE only.
REQ-007 mul_i / div_i  in  8 each  M/D values captured on accepted start.
REQ-008 phase_i  in  9  phase value captured on accepted start.
REQ-009 busy_o  out  1  high while a sequence is in progress.
REQ-010 done_o  out  1  one-cycle pulse at sequence end (success or failure).
REQ-011 error_o  out  1  failure flag; err_code_o  out  2  01 = generator done/lock timeout, 10 = ADC DCM lock timeout, 11 = phase-done timeout, 00 = none.
REQ-012 clkgen_reset_o  out  1; clkgen_mul_o / clkgen_div_o  out  8 each; clkgen_load_o  out  1; clkgen_done_i  in  1: generator M/D load interface.
REQ-013 gen_locked_i  in  1  generator DCM lock status; adc_locked_i  in  1  ADC DCM lock status; dcm_reset_o  out  1  ADC DCM reset.
REQ-014 phase_requested_o  out  9; phase_load_o  out  1; phase_done_i  in  1: phase-shift interface.

Function
REQ-015 States SHALL be IDLE, GEN_RST, GEN_LOAD, GEN_WAITDONE, GEN_WAITLOCK, ADC_WAITLOCK, PHASE_LOAD, PHASE_WAIT, FINISH, FAIL.
REQ-016 IDLE, start_i=1: capture mul_i/div_i/phase_i onto clkgen_mul_o/clkgen_div_o/phase_requested_o, clear error_o and err_code_o, go to GEN_RST; busy_o=1 from the next cycle.
REQ-017 start_i outside IDLE SHALL be ignored; captured values SHALL stay constant until the next accepted start.
REQ-018 GEN_RST: clkgen_reset_o=1 for exactly RESET_CYCLES cycles, then GEN_LOAD.
REQ-019 dcm_reset_o SHALL be 1 in every state from GEN_RST through GEN_WAITLOCK inclusive, and 0 otherwise.
REQ-020 GEN_LOAD: clkgen_load_o=1 for exactly one cycle, then GEN_WAITDONE.
REQ-021 GEN_WAITDONE: advance to GEN_WAITLOCK on a rising edge of clkgen_done_i (sampled 0, then 1); a level already high on entry SHALL NOT count.
REQ-022 GEN_WAITLOCK / ADC_WAITLOCK: a stability counter increments while the lock input is 1 and clears to 0 on any 0; advance when it reaches LOCK_STABLE.
REQ-023 GEN_WAITLOCK advances to ADC_WAITLOCK; ADC_WAITLOCK (lock input adc_locked_i) advances to PHASE_LOAD.
REQ-024 PHASE_LOAD: phase_load_o=1 for exactly one cycle, then PHASE_WAIT; PHASE_WAIT advances to FINISH on a rising edge of phase_done_i.
REQ-025 Timeout counter SHALL clear on entry to each wait state and increment each cycle in it; if the advance condition is unmet after TIMEOUT cycles in the state, go to FAIL with err_code per REQ-011.
REQ-026 An advance condition and a timeout in the same cycle SHALL resolve as advance.
REQ-027 FINISH: done_o=1 for one cycle, error_o=0, then IDLE.
REQ-028 FAIL: done_o=1 for one cycle, error_o=1, err_code_o set, then IDLE. error_o/err_code_o SHALL hold until the next accepted start or reset.
REQ-029 busy_o SHALL be 0 in IDLE and 1 in all other states, including FINISH/FAIL; done_o SHALL coincide with the last busy cycle.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 reset_i=1 SHALL force IDLE on the next edge from any state, including mid-sequence.
REQ-032 Reset SHALL clear all outputs, captured registers, and counters to 0, with no done_o pulse.

Verification (RESET_CYCLES=4, LOCK_STABLE=4, TIMEOUT=100)
REQ-033 Nominal: start with mul=0x05, div=0x02, phase=0x040; model done edges after 10 cycles and locks steady.
  -> clkgen_reset_o high exactly 4 cycles; one clkgen_load_o pulse; one phase_load_o pulse with phase_requested_o=0x040; done_o=1 with error_o=0.
REQ-034 Generator timeout: clkgen_done_i never rises.
  -> FAIL 100 cycles after GEN_WAITDONE entry; err_code_o=01; done_o pulse; error_o stays 1 until the next start.
REQ-035 Lock glitch: adc_locked_i pattern 1,1,1,0,1,1,1,1.
  -> advance only after the final 4 consecutive highs; dcm_reset_o=0 throughout ADC_WAITLOCK.
REQ-036 Stale done: clkgen_done_i held high before and through GEN_WAITDONE entry.
  -> no advance until it drops and rises again.
REQ-037 Start while busy, plus mid-sequence reset: second start with new mul during PHASE_WAIT, then reset_i in GEN_WAITLOCK of a later run.
  -> second start ignored and clkgen_mul_o unchanged; after reset all outputs 0, state IDLE, no done_o.

Source files
------------

// File: rtl/clock_reconfig_sequencer.sv
// Clock reconfiguration sequencer.
// Resets the generator DCM, loads new M/D values, waits for the generator
// to report done and lock, then waits for the ADC DCM lock and finally
// applies a phase shift. Every wait is guarded by a timeout. A failed wait
// ends the sequence with an error code that holds until the next start.
module clock_reconfig_sequencer #(
  parameter int RESET_CYCLES = 8,
  parameter int LOCK_STABLE  = 16,
  parameter int TIMEOUT      = 1000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] mul_i,
  input  logic [7:0] div_i,
  input  logic [8:0] phase_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [1:0] err_code_o,
  output logic       clkgen_reset_o,
  output logic [7:0] clkgen_mul_o,
  output logic [7:0] clkgen_div_o,
  output logic       clkgen_load_o,
  input  logic       clkgen_done_i,
  input  logic       gen_locked_i,
  input  logic       adc_locked_i,
  output logic       dcm_reset_o,
  output logic [8:0] phase_requested_o,
  output logic       phase_load_o,
  input  logic       phase_done_i
);

  localparam logic [19:0] RST_LAST = 20'(RESET_CYCLES - 1);
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);
  localparam logic [7:0]  LS_LAST  = 8'(LOCK_STABLE - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GEN_RST,
    S_GEN_LOAD,
    S_GEN_WAITDONE,
    S_GEN_WAITLOCK,
    S_ADC_WAITLOCK,
    S_PHASE_LOAD,
    S_PHASE_WAIT,
    S_FINISH,
    S_FAIL
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;        // reset-pulse length and per-state timeout
  logic [7:0]  stab_q, stab_d;      // consecutive locked cycles
  logic        seen_low_q, seen_low_d;
  logic [1:0]  fail_code_d;

  logic edge_in;
  logic lock_in;
  logic timed_out;

  // The two edge-wait states and the two lock-wait states share one
  // detector each; the current state selects which input feeds it.
  assign edge_in   = (state_q == S_PHASE_WAIT) ? phase_done_i : clkgen_done_i;
  assign lock_in   = (state_q == S_ADC_WAITLOCK) ? adc_locked_i : gen_locked_i;
  assign timed_out = (cnt_q == TMO_LAST);

  // Next-state, counter and failure-code selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 20'd1;
    stab_d      = '0;
    seen_low_d  = 1'b0;
    fail_code_d = 2'b00;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_i) state_d = S_GEN_RST;
      end
      S_GEN_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_GEN_LOAD;
          cnt_d   = '0;
        end
      end
      S_GEN_LOAD: begin
        state_d = S_GEN_WAITDONE;
        cnt_d   = '0;
      end
      // A rising edge needs a low sample inside the state first, so a level
      // that is already high on entry never counts.
      S_GEN_WAITDONE, S_PHASE_WAIT: begin
        seen_low_d = seen_low_q | ~edge_in;
        if (edge_in && seen_low_q) begin
          state_d    = (state_q == S_GEN_WAITDONE) ? S_GEN_WAITLOCK : S_FINISH;
          cnt_d      = '0;
          seen_low_d = 1'b0;
        end else if (timed_out) begin
          state_d     = S_FAIL;
          fail_code_d = (state_q == S_GEN_WAITDONE) ? 2'b01 : 2'b11;
        end
      end
      S_GEN_WAITLOCK, S_ADC_WAITLOCK: begin
        stab_d = lock_in ? (stab_q + 8'd1) : '0;
        if (lock_in && (stab_q == LS_LAST)) begin
          state_d = (state_q == S_GEN_WAITLOCK) ? S_ADC_WAITLOCK : S_PHASE_LOAD;
          cnt_d   = '0;
          stab_d  = '0;
        end else if (timed_out) begin
          state_d     = S_FAIL;
          fail_code_d = (state_q == S_GEN_WAITLOCK) ? 2'b01 : 2'b10;
        end
      end
      S_PHASE_LOAD: begin
        state_d = S_PHASE_WAIT;
        cnt_d   = '0;
      end
      S_FINISH, S_FAIL: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      stab_q            <= '0;
      seen_low_q        <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      error_o           <= 1'b0;
      err_code_o        <= '0;
      clkgen_reset_o    <= 1'b0;
      clkgen_mul_o      <= '0;
      clkgen_div_o      <= '0;
      clkgen_load_o     <= 1'b0;
      dcm_reset_o       <= 1'b0;
      phase_requested_o <= '0;
      phase_load_o      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stab_q         <= stab_d;
      seen_low_q     <= seen_low_d;
      busy_o         <= (state_d != S_IDLE);
      done_o         <= (state_d == S_FINISH) || (state_d == S_FAIL);
      clkgen_reset_o <= (state_d == S_GEN_RST);
      clkgen_load_o  <= (state_d == S_GEN_LOAD);
      phase_load_o   <= (state_d == S_PHASE_LOAD);
      dcm_reset_o    <= (state_d == S_GEN_RST)      || (state_d == S_GEN_LOAD) ||
                        (state_d == S_GEN_WAITDONE) || (state_d == S_GEN_WAITLOCK);
      if ((state_q == S_IDLE) && start_i) begin
        clkgen_mul_o      <= mul_i;
        clkgen_div_o      <= div_i;
        phase_requested_o <= phase_i;
        error_o           <= 1'b0;
        err_code_o        <= '0;
      end
      if (state_d == S_FAIL) begin
        error_o    <= 1'b1;
        err_code_o <= fail_code_d;
      end
    end
  end

endmodule

// File: tb/tb_clock_reconfig_sequencer.sv
// Directed bench for clock_reconfig_sequencer with a procedural reference
// model compared against every output on every cycle after the first reset.
module tb_clock_reconfig_sequencer;

  localparam int RC = 4;
  localparam int LS = 4;
  localparam int TO = 100;

  localparam int W_LOAD  = 0;
  localparam int W_PLOAD = 1;
  localparam int W_DONE  = 2;
  localparam int W_ADC   = 3;

  logic       clk = 1'b0;
  logic       reset_i, start_i;
  logic [7:0] mul_i, div_i;
  logic [8:0] phase_i;
  logic       busy_o, done_o, error_o;
  logic [1:0] err_code_o;
  logic       clkgen_reset_o, clkgen_load_o, clkgen_done_i;
  logic [7:0] clkgen_mul_o, clkgen_div_o;
  logic       gen_locked_i, adc_locked_i, dcm_reset_o;
  logic [8:0] phase_requested_o;
  logic       phase_load_o, phase_done_i;

  clock_reconfig_sequencer #(
    .RESET_CYCLES(RC),
    .LOCK_STABLE (LS),
    .TIMEOUT     (TO)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .mul_i            (mul_i),
    .div_i            (div_i),
    .phase_i          (phase_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .error_o          (error_o),
    .err_code_o       (err_code_o),
    .clkgen_reset_o   (clkgen_reset_o),
    .clkgen_mul_o     (clkgen_mul_o),
    .clkgen_div_o     (clkgen_div_o),
    .clkgen_load_o    (clkgen_load_o),
    .clkgen_done_i    (clkgen_done_i),
    .gen_locked_i     (gen_locked_i),
    .adc_locked_i     (adc_locked_i),
    .dcm_reset_o      (dcm_reset_o),
    .phase_requested_o(phase_requested_o),
    .phase_load_o     (phase_load_o),
    .phase_done_i     (phase_done_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit       m_valid = 1'b0;
  bit       e_busy, e_done, e_err, e_crst, e_load, e_dcm, e_pload;
  bit [1:0] e_code;
  bit [7:0] e_mul, e_div;
  bit [8:0] e_phase;

  task automatic m_zero();
    e_busy = 0; e_done = 0; e_err = 0; e_crst = 0; e_load = 0; e_dcm = 0;
    e_pload = 0; e_code = 0; e_mul = 0; e_div = 0; e_phase = 0;
  endtask

  task automatic m_tick(output bit rst);
    @(posedge clk);
    rst = reset_i;
    if (rst) m_zero();
  endtask

  // Waits inside one state. kind: 0 gen done edge, 1 gen lock, 2 adc lock,
  // 3 phase done edge. r: 0 advanced, 1 timed out, 2 reset.
  task automatic m_wait(input int kind, output int r);
    int n = 0;
    int run = 0;
    bit low = 0;
    bit in, rst;
    forever begin
      m_tick(rst);
      if (rst) begin r = 2; return; end
      n++;
      case (kind)
        0: in = clkgen_done_i;
        1: in = gen_locked_i;
        2: in = adc_locked_i;
        default: in = phase_done_i;
      endcase
      if (kind == 0 || kind == 3) begin
        if (in && low) begin r = 0; return; end
        if (!in) low = 1;
      end else begin
        run = in ? run + 1 : 0;
        if (run == LS) begin r = 0; return; end
      end
      if (n == TO) begin r = 1; return; end
    end
  endtask

  task automatic m_end();
    bit rst;
    m_tick(rst);
    if (!rst) begin e_busy = 0; e_done = 0; end
  endtask

  task automatic m_fail(input bit [1:0] code);
    e_dcm = 0; e_done = 1; e_err = 1; e_code = code;
    m_end();
  endtask

  task automatic m_run();
    bit rst;
    int r;
    e_busy = 1; e_dcm = 1; e_crst = 1; e_load = 0; e_pload = 0; e_done = 0;
    for (int i = 1; i < RC; i++) begin
      m_tick(rst);
      if (rst) return;
    end
    m_tick(rst); if (rst) return;
    e_crst = 0; e_load = 1;
    m_tick(rst); if (rst) return;
    e_load = 0;
    m_wait(0, r); if (r == 2) return; if (r == 1) begin m_fail(2'b01); return; end
    m_wait(1, r); if (r == 2) return; if (r == 1) begin m_fail(2'b01); return; end
    e_dcm = 0;
    m_wait(2, r); if (r == 2) return; if (r == 1) begin m_fail(2'b10); return; end
    e_pload = 1;
    m_tick(rst); if (rst) return;
    e_pload = 0;
    m_wait(3, r); if (r == 2) return; if (r == 1) begin m_fail(2'b11); return; end
    e_done = 1;
    m_end();
  endtask

  initial begin
    m_zero();
    forever begin
      @(posedge clk);
      if (reset_i) begin
        m_zero();
        m_valid = 1'b1;
      end else if (start_i) begin
        e_mul = mul_i; e_div = div_i; e_phase = phase_i;
        e_err = 0; e_code = 0;
        m_run();
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy_o",            32'(busy_o),            32'(e_busy));
      chk("done_o",            32'(done_o),            32'(e_done));
      chk("error_o",           32'(error_o),           32'(e_err));
      chk("err_code_o",        32'(err_code_o),        32'(e_code));
      chk("clkgen_reset_o",    32'(clkgen_reset_o),    32'(e_crst));
      chk("clkgen_load_o",     32'(clkgen_load_o),     32'(e_load));
      chk("dcm_reset_o",       32'(dcm_reset_o),       32'(e_dcm));
      chk("phase_load_o",      32'(phase_load_o),      32'(e_pload));
      chk("clkgen_mul_o",      32'(clkgen_mul_o),      32'(e_mul));
      chk("clkgen_div_o",      32'(clkgen_div_o),      32'(e_div));
      chk("phase_requested_o", 32'(phase_requested_o), 32'(e_phase));
    end
  end

  // Pulse/level counters used by the hand-computed checks.
  int n_crst = 0, n_load = 0, n_pload = 0, n_done = 0;
  always @(negedge clk) begin
    if (clkgen_reset_o) n_crst++;
    if (clkgen_load_o)  n_load++;
    if (phase_load_o)   n_pload++;
    if (done_o)         n_done++;
  end

  // ---------------- stimulus helpers ----------------
  int b_crst, b_load, b_pload, b_done;

  task automatic do_start(input logic [7:0] m, input logic [7:0] d, input logic [8:0] p);
    @(negedge clk);
    b_crst = n_crst; b_load = n_load; b_pload = n_pload; b_done = n_done;
    mul_i = m; div_i = d; phase_i = p; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_sig(input int which, input int budget, output int at);
    logic hit;
    at = -1;
    checks++;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (which)
        W_LOAD:  hit = clkgen_load_o;
        W_PLOAD: hit = phase_load_o;
        W_DONE:  hit = done_o;
        default: hit = busy_o && !dcm_reset_o;
      endcase
      if (hit) begin at = cyc; return; end
    end
    errors++;
    $display("FAIL wait_event_%0d: got no event in %0d cycles, expected event", which, budget);
  endtask

  task automatic finish_idle(input string tag);
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    clkgen_done_i = 1'b0; phase_done_i = 1'b0;
    gen_locked_i = 1'b1; adc_locked_i = 1'b1;
  endtask

  int  L, P, D, A;
  bit  pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    reset_i = 1'b1; start_i = 1'b0; mul_i = '0; div_i = '0; phase_i = '0;
    clkgen_done_i = 1'b0; gen_locked_i = 1'b1; adc_locked_i = 1'b1; phase_done_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    chk("rst_ctrl", 32'({busy_o, done_o, error_o, err_code_o, clkgen_reset_o,
                         clkgen_load_o, dcm_reset_o, phase_load_o}), 32'd0);
    chk("rst_data", 32'({clkgen_mul_o, clkgen_div_o, phase_requested_o}), 32'd0);

    // Nominal sequence.
    do_start(8'h05, 8'h02, 9'h040);
    wait_sig(W_LOAD, 20, L);
    repeat (10) @(negedge clk);
    clkgen_done_i = 1'b1;
    wait_sig(W_PLOAD, 40, P);
    chk("nom_phase_req", 32'(phase_requested_o), 32'h040);
    chk("nom_pload_lat", 32'(P - L), 32'd19);
    repeat (3) @(negedge clk);
    phase_done_i = 1'b1;
    wait_sig(W_DONE, 20, D);
    chk("nom_done_lat", 32'(D - P), 32'd4);
    chk("nom_error", 32'(error_o), 32'd0);
    chk("nom_crst_cycles", 32'(n_crst - b_crst), 32'd4);
    chk("nom_load_pulses", 32'(n_load - b_load), 32'd1);
    chk("nom_pload_pulses", 32'(n_pload - b_pload), 32'd1);
    finish_idle("nom");

    // Generator done never rises.
    do_start(8'h11, 8'h22, 9'h123);
    wait_sig(W_LOAD, 20, L);
    wait_sig(W_DONE, 150, D);
    chk("gto_lat", 32'(D - L), 32'd101);
    chk("gto_code", 32'(err_code_o), 32'd1);
    chk("gto_error", 32'(error_o), 32'd1);
    repeat (5) @(negedge clk);
    chk("gto_hold", 32'({error_o, err_code_o}), 32'b101);
    finish_idle("gto");

    // ADC lock glitch.
    adc_locked_i = 1'b0;
    do_start(8'h07, 8'h03, 9'h1FF);
    chk("glitch_err_cleared", 32'(error_o), 32'd0);
    wait_sig(W_LOAD, 20, L);
    repeat (10) @(negedge clk);
    clkgen_done_i = 1'b1;
    wait_sig(W_ADC, 30, A);
    adc_locked_i = pat[0];
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      adc_locked_i = pat[k];
    end
    wait_sig(W_PLOAD, 20, P);
    chk("glitch_adc_lat", 32'(P - A), 32'd8);
    repeat (3) @(negedge clk);
    phase_done_i = 1'b1;
    wait_sig(W_DONE, 20, D);
    chk("glitch_error", 32'(error_o), 32'd0);
    finish_idle("glitch");

    // Stale generator done, then a start while busy.
    clkgen_done_i = 1'b1;
    do_start(8'h3C, 8'h04, 9'h0A5);
    wait_sig(W_LOAD, 20, L);
    repeat (6) @(negedge clk);
    clkgen_done_i = 1'b0;
    repeat (2) @(negedge clk);
    clkgen_done_i = 1'b1;
    wait_sig(W_PLOAD, 40, P);
    chk("stale_pload_lat", 32'(P - L), 32'd17);
    @(negedge clk);
    mul_i = 8'hAA; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_start_mul", 32'(clkgen_mul_o), 32'h3C);
    @(negedge clk);
    phase_done_i = 1'b1;
    wait_sig(W_DONE, 20, D);
    chk("busy_start_done_lat", 32'(D - P), 32'd4);
    chk("busy_start_mul_end", 32'(clkgen_mul_o), 32'h3C);
    finish_idle("stale");
    repeat (3) @(negedge clk);
    chk("no_restart", 32'(busy_o), 32'd0);

    // ADC lock never arrives.
    adc_locked_i = 1'b0;
    do_start(8'h09, 8'h01, 9'h010);
    wait_sig(W_LOAD, 20, L);
    repeat (2) @(negedge clk);
    clkgen_done_i = 1'b1;
    wait_sig(W_ADC, 30, A);
    wait_sig(W_DONE, 150, D);
    chk("ato_lat", 32'(D - A), 32'd100);
    chk("ato_code", 32'(err_code_o), 32'd2);
    finish_idle("ato");

    // Phase done never arrives.
    do_start(8'h0B, 8'h05, 9'h100);
    wait_sig(W_LOAD, 20, L);
    repeat (2) @(negedge clk);
    clkgen_done_i = 1'b1;
    wait_sig(W_PLOAD, 40, P);
    wait_sig(W_DONE, 150, D);
    chk("pto_lat", 32'(D - P), 32'd101);
    chk("pto_code", 32'(err_code_o), 32'd3);
    finish_idle("pto");

    // Reset in the middle of GEN_WAITLOCK.
    do_start(8'h77, 8'h66, 9'h055);
    wait_sig(W_LOAD, 20, L);
    repeat (2) @(negedge clk);
    clkgen_done_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("mrst_ctrl", 32'({busy_o, done_o, error_o, err_code_o, clkgen_reset_o,
                          clkgen_load_o, dcm_reset_o, phase_load_o}), 32'd0);
    chk("mrst_data", 32'({clkgen_mul_o, clkgen_div_o, phase_requested_o}), 32'd0);
    repeat (3) @(negedge clk);
    chk("mrst_no_done", 32'(n_done - b_done), 32'd0);
    chk("mrst_idle", 32'(busy_o), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
